// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
//   load_valid  word presented on data_in
//   load_ready  serializer idle and able to take a word
//   data_in     parallel word, sampled only when a load fires
//   en          shift enable
//   sdata       registered serial data, MSB first
//   sframe      registered, high while a frame's bits are on sdata
//   done        registered one-cycle pulse after the last bit
// master: the side that supplies words and consumes the serial stream.
// slave:  the serializer itself.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             en;
  logic             sdata;
  logic             sframe;
  logic             done;

  modport master (
    output load_valid, data_in, en,
    input  load_ready, sdata, sframe, done
  );

  modport slave (
    input  load_valid, data_in, en,
    output load_ready, sdata, sframe, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Takes a WIDTH-bit word on a valid/ready
// load and shifts it out MSB first, one bit per enabled clock, with a frame
// strobe over the active bits and a done pulse after the last bit.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-high reset
//   io_bus   piso_serializer_if slave modport (handshake, enable, serial out)
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  piso_serializer_if.slave io_bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic             r_sdata, w_sdata_d;
  logic             r_sframe, w_sframe_d;
  logic             r_done, w_done_d;
  logic             w_load_ready;
  logic             w_load;

  // Ready is masked by reset so no word is accepted on a reset edge.
  assign w_load_ready = (r_state == StIdle) && !i_reset;
  assign w_load       = io_bus.load_valid && w_load_ready;

  // State register (FSM state plus datapath registers).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_sdata   <= 1'b0;
      r_sframe  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shreg   <= w_shreg_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_sdata   <= w_sdata_d;
      r_sframe  <= w_sframe_d;
      r_done    <= w_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_load) w_state_d = StShift;
      StShift: if (io_bus.en && (r_bit_cnt == '0)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output / datapath logic. The MSB goes straight to sdata on the load edge,
  // so the shift register only ever holds the remaining WIDTH-1 bits.
  always_comb begin
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    w_sdata_d   = r_sdata;
    w_sframe_d  = r_sframe;
    w_done_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sdata_d  = 1'b0;
        w_sframe_d = 1'b0;
        if (w_load) begin
          w_sdata_d   = io_bus.data_in[WIDTH-1];
          w_shreg_d   = {io_bus.data_in[WIDTH-2:0], 1'b0};
          w_bit_cnt_d = CntW'(WIDTH - 1);
          w_sframe_d  = 1'b1;
        end
      end
      StShift: begin
        if (io_bus.en) begin
          if (r_bit_cnt != '0) begin
            w_sdata_d   = r_shreg[WIDTH-1];
            w_shreg_d   = r_shreg << 1;
            w_bit_cnt_d = r_bit_cnt - 1'b1;
          end else begin
            w_sdata_d  = 1'b0;
            w_sframe_d = 1'b0;
            w_done_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign io_bus.load_ready = w_load_ready;
  assign io_bus.sdata      = r_sdata;
  assign io_bus.sframe     = r_sframe;
  assign io_bus.done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=8). Stimulus pushes the expected
// serial stream (bits 0/1, done marker 2) into a queue; a negedge monitor pops
// and compares each time the DUT presents a new bit or a done pulse.
module tb_piso_serializer;
  localparam int unsigned W = 8;
  localparam int DoneTok = 2;

  logic clk = 1'b0;
  logic reset;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int   q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   starts = 0;
  int   mon_e;
  logic en_edge = 1'b0;
  logic sframe_prev = 1'b0;
  logic last_bit = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter and the enable value seen by the DUT at each edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_edge <= bus.en;
  end

  // Monitor: a new bit is on sdata after a load edge or an enabled edge;
  // otherwise a framed cycle must hold the previous bit.
  always @(negedge clk) begin
    if (bus.sframe === 1'b1) begin
      if (!sframe_prev || en_edge) begin
        if (!sframe_prev) starts++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got sdata=%0d expected no frame", bus.sdata);
        end else begin
          mon_e = q.pop_front();
          chk("stream", int'(bus.sdata), mon_e);
        end
        last_bit = bus.sdata;
      end else begin
        chk("stall_hold", int'(bus.sdata), int'(last_bit));
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        mon_e = q.pop_front();
        chk("stream", DoneTok, mon_e);
      end
      chk("done_sdata", int'(bus.sdata), 0);
      chk("done_sframe", int'(bus.sframe), 0);
      chk("done_ready", int'(bus.load_ready), 1);
    end
    sframe_prev = bus.sframe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(int'(d[i]));
    q.push_back(DoneTok);
  endtask

  // Present a word and return the cycle number of the edge that took it.
  task automatic do_load(input logic [W-1:0] d, output int lcyc);
    bit ok;
    ok   = 1'b0;
    lcyc = -1;
    tick();
    bus.load_valid = 1'b1;
    bus.data_in    = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.load_ready) begin
        @(posedge clk);
        #1;
        lcyc           = cyc;
        bus.load_valid = 1'b0;
        ok             = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got load_ready=0 expected 1 within 40 cycles");
      bus.load_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int maxc, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", maxc);
    end
  endtask

  int l, l2, d, d2, dc;

  initial begin
    reset          = 1'b1;
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hFF;
    bus.en         = 1'b1;

    // Reset with a pending load.
    repeat (2) begin
      @(negedge clk);
      chk("reset_sdata", int'(bus.sdata), 0);
      chk("reset_sframe", int'(bus.sframe), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_ready", int'(bus.load_ready), 0);
    end
    tick();
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.load_ready), 1);

    // Basic frame.
    push_frame(8'hA5);
    do_load(8'hA5, l);
    wait_done(20, d);
    chk("basic_done_latency", d - l, 8);

    // Enable gating: 3 stalled edges after bit 6.
    push_frame(8'hC3);
    do_load(8'hC3, l);
    tick();
    bus.en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("gate_sdata", int'(bus.sdata), 1);
      chk("gate_sframe", int'(bus.sframe), 1);
      tick();
    end
    bus.en = 1'b1;
    wait_done(30, d);
    chk("gated_done_latency", d - l, 11);

    // Back-to-back with load_valid held high.
    push_frame(8'h81);
    push_frame(8'h7E);
    tick();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h81;
    tick();
    l           = cyc;
    bus.data_in = 8'h7E;
    wait_done(20, d);
    chk("b2b_first_latency", d - l, 8);
    @(negedge clk);
    chk("b2b_second_started", int'(bus.sframe), 1);
    bus.load_valid = 1'b0;
    l2 = d + 1;
    wait_done(20, d2);
    chk("b2b_second_latency", d2 - l2, 8);

    // Reset after 3 bits of a frame.
    q.push_back(1);
    q.push_back(1);
    q.push_back(1);
    do_load(8'hF0, l);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sframe", int'(bus.sframe), 0);
    chk("abort_sdata", int'(bus.sdata), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_ready", int'(bus.load_ready), 1);
    dc = done_cnt;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);

    // Load pulse during an active frame is ignored.
    push_frame(8'h3C);
    do_load(8'h3C, l);
    tick();
    tick();
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h00;
    @(negedge clk);
    chk("ignored_ready", int'(bus.load_ready), 0);
    tick();
    bus.load_valid = 1'b0;
    wait_done(20, d);
    chk("ignored_done_latency", d - l, 8);
    repeat (12) @(negedge clk);

    chk("frame_count", starts, 6);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter built on the clocked-enable storage style of the team's D flip-flop. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB first, one bit per enabled clock. A frame strobe marks the active bits, and a done pulse follows the last bit. It is the transmit end that feeds a serial-in/parallel-out capture chain on the Basys 3 designs.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  a word is presented on data_in.
- load_ready  output  1  block can accept a word; equals (state == IDLE) and not reset.
- data_in  input  WIDTH  parallel word; sampled only on a load.
- en  input  1  shift enable; when low in SHIFT, all state holds.
- sdata  output  1  registered serial data, MSB first.
- sframe  output  1  registered; high while a frame's bits are on sdata.
- done  output  1  registered one-cycle pulse after the last bit of a frame.

## Operation
- Internal state: `state` (IDLE or SHIFT), `shreg[WIDTH-1:0]`, `bit_cnt[$clog2(WIDTH)-1:0]`.
- Reset (reset=1 at an edge):
  - state <= IDLE; shreg, bit_cnt, sdata, sframe, done <= 0.
  - load_ready is 0 while reset is high.
  - Reset has priority over load and shift, including mid-frame: the partial frame is abandoned and no done pulse is produced.
- IDLE:
  - load_ready=1, sframe=0, sdata=0.
  - A load fires on an edge with load_valid & load_ready. On that edge:
    - sdata <= data_in[WIDTH-1]
    - shreg <= {data_in[WIDTH-2:0], 1'b0}
    - bit_cnt <= WIDTH-1
    - sframe <= 1; state <= SHIFT
  - A load does not depend on en.
  - done <= 0 on every IDLE edge, so it is a single-cycle pulse.
- SHIFT:
  - load_ready=0. load_valid and data_in are ignored.
  - en=0: shreg, bit_cnt, sdata, sframe and state all hold; done=0.
  - en=1 and bit_cnt != 0: sdata <= shreg[WIDTH-1]; shreg <= shreg << 1; bit_cnt <= bit_cnt - 1.
  - en=1 and bit_cnt == 0: sdata <= 0; sframe <= 0; done <= 1; state <= IDLE.
- No wrap-around: bit_cnt never decrements below 0.
- Shifting inserts zeros at the LSB.

## Timing
- Load edge E0: after E0, sdata = MSB and sframe = 1.
- Each later edge with en=1 advances one bit. The LSB is on sdata after the (WIDTH-1)th enabled edge following E0.
- On the WIDTH-th enabled edge after E0: sframe falls, sdata = 0, done = 1 for exactly one cycle.
- With en held high, a frame is exactly WIDTH cycles of sframe=1, followed by 1 cycle of done=1.
- load_ready rises in the same cycle as done. The earliest next load is the edge at the end of the done cycle.
  - Minimum inter-frame gap with sframe=0 is 1 cycle.
  - A load and a final shift never occur on the same edge.
- Cycles with en=0 stretch the current bit. They do not change the bit count.
- load_valid held high while load_ready=0 has no effect. The word is taken on the first edge where both are high.

## Test plan
- Reset: drive reset=1 for 2 cycles with load_valid=1, data_in=8'hFF.
  - Required: sdata=0, sframe=0, done=0, load_ready=0 during reset.
  - Required: load_ready=1 in the first cycle after reset drops.
- Basic frame: WIDTH=8, en=1, load 8'hA5.
  - Required: sdata sequence 1,0,1,0,0,1,0,1 over 8 cycles with sframe=1.
  - Required: then done=1 for 1 cycle, sframe=0, sdata=0.
- Enable gating: load 8'hC3, en=1 for 2 cycles, en=0 for 3 cycles, then en=1.
  - Required: sdata stays 1 (bit 6) through the 3 stalled cycles.
  - Required: full sequence 1,1,0,0,0,0,1,1 completes; done appears 3 cycles later than the ungated case.
- Back-to-back: keep load_valid=1, data_in=8'h81 then 8'h7E.
  - Required: second load occurs on the done-cycle edge.
  - Required: exactly 1 cycle of sframe=0 between frames; second frame reads 0,1,1,1,1,1,1,0.
- Reset mid-frame: load 8'hF0, assert reset after 3 bits.
  - Required: next cycle sframe=0, sdata=0, done never pulses, load_ready=1 once reset is released.
- Ignored load: during an active frame, pulse load_valid with data_in=8'h00.
  - Required: the frame in progress is unchanged and no extra frame follows.
